// File: rtl/filter_capture.sv
// filter_capture: latency-matched capture of FIR results, decimation, show-ahead FIFO.
// Define FILTER_CAPTURE_WARMUP_SKIP_EN to discard the first TAPS captures after reset/clear.
module filter_capture #(
  parameter int LATENCY = 5,
  parameter int DECIM   = 1,
  parameter int DEPTH   = 16,
  parameter int TAPS    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [15:0]              filter_data,
  input  logic                     clear,
  output logic [15:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DECIM - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);

  logic [LATENCY-1:0] pipe;
  logic [LATENCY-1:0] pipe_nxt;
  logic               cap;
  logic               elig;
  logic               keep;
  logic               pop;
  logic               push;
  logic               drop;
  logic               empty_nxt;
  logic [PW-1:0]      phase;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW-1:0]      rnext;
  logic [AW:0]        lvl_nxt;
  logic [15:0]        head_nxt;
  logic [15:0]        mem [DEPTH];

  generate
    if (LATENCY == 1) begin : g_p1
      assign pipe_nxt = enable;
    end else begin : g_pn
      assign pipe_nxt = {pipe[LATENCY-2:0], enable};
    end
  endgenerate

  assign cap = pipe[LATENCY-1];

`ifdef FILTER_CAPTURE_WARMUP_SKIP_EN
  localparam logic [7:0] TW = 8'(TAPS);
  logic [7:0] warm;

  assign elig = cap && (warm >= TW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm <= '0;
    end else if (clear) begin
      warm <= '0;
    end else if (cap && (warm < TW)) begin
      warm <= warm + 8'd1;
    end
  end
`else
  assign elig = cap;
`endif

  assign keep  = elig && (phase == '0);
  assign pop   = m_valid && m_ready;
  assign push  = keep && ((level != FULL) || pop);
  assign drop  = keep && !push;
  assign rnext = rptr + 1'b1;

  always_comb begin
    lvl_nxt = level;
    unique case ({push, pop})
      2'b10:   lvl_nxt = level + ONE;
      2'b01:   lvl_nxt = level - ONE;
      default: ;
    endcase
  end

  // Head register: next entry on pop, or the incoming sample when the FIFO would be empty.
  assign empty_nxt = !m_valid || (pop && (level == ONE));

  always_comb begin
    head_nxt = m_data;
    unique case (1'b1)
      pop && (level > ONE): head_nxt = mem[rnext];
      push && empty_nxt:    head_nxt = filter_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= filter_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe     <= '0;
      phase    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      pipe     <= '0;
      phase    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      m_valid  <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      pipe <= pipe_nxt;
      if (elig) begin
        phase <= (phase == PMAX) ? '0 : phase + 1'b1;
      end
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rnext;
      end
      level   <= lvl_nxt;
      m_valid <= (lvl_nxt != '0);
      m_data  <= head_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_capture.sv
// tb_filter_capture: two DUTs (DECIM=1 and DECIM=4) against a queue-based model.
// Honours FILTER_CAPTURE_WARMUP_SKIP_EN in the model and the pinned expectations.
module tb_filter_capture;

  localparam int LAT  = 5;
  localparam int DEP  = 16;
  localparam int TAPS = 32;
  localparam int NLOG = 10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] filter_data = '0;

  logic [15:0] md [2];
  logic        mv [2];
  logic [4:0]  lv [2];
  logic        ov [2];
  logic [7:0]  dc [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  filter_capture #(
    .LATENCY(LAT), .DECIM(1), .DEPTH(DEP), .TAPS(TAPS)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .filter_data(filter_data), .clear(clear),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(m_ready),
    .level(lv[0]), .overflow(ov[0]), .drop_cnt(dc[0])
  );

  filter_capture #(
    .LATENCY(LAT), .DECIM(4), .DEPTH(DEP), .TAPS(TAPS)
  ) u_d4 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .filter_data(filter_data), .clear(clear),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(m_ready),
    .level(lv[1]), .overflow(ov[1]), .drop_cnt(dc[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: a capture at edge k is the enable seen LAT edges
  // earlier, provided that edge came after the last reset/clear.
  int          dec [2] = '{1, 4};
  bit          en_log [NLOG];
  int          k = 0;
  int          last_clr = 0;
  logic [15:0] mq [2][DEP];
  int          mh [2];
  int          ms [2];
  int          ncap [2];
  int          warm [2];
  bit          mov [2];
  int          mdc [2];
  logic [15:0] mhead [2];

  always @(posedge clk) begin
    bit c;
    bit kp;
    bit pp;
    bit fl;
    if (k < NLOG) en_log[k] = enable;
    if (!rst_n || clear) begin
      last_clr = k;
      for (int i = 0; i < 2; i++) begin
        ms[i] = 0;
        mh[i] = 0;
        ncap[i] = 0;
        warm[i] = 0;
        mov[i] = 0;
        mdc[i] = 0;
        if (!rst_n) mhead[i] = '0;
      end
    end else begin
      c = 1'b0;
      if (k - LAT > last_clr) c = en_log[k-LAT];
      for (int i = 0; i < 2; i++) begin
        kp = 1'b0;
        if (c) begin
`ifdef FILTER_CAPTURE_WARMUP_SKIP_EN
          if (warm[i] < TAPS) begin
            warm[i]++;
          end else begin
            kp = (ncap[i] % dec[i]) == 0;
            ncap[i]++;
          end
`else
          kp = (ncap[i] % dec[i]) == 0;
          ncap[i]++;
`endif
        end
        pp = (ms[i] > 0) && m_ready;
        fl = (ms[i] == DEP);
        if (pp) begin
          mh[i] = (mh[i] + 1) % DEP;
          ms[i]--;
        end
        if (kp) begin
          if (!fl || pp) begin
            mq[i][(mh[i] + ms[i]) % DEP] = filter_data;
            ms[i]++;
          end else begin
            mov[i] = 1'b1;
            if (mdc[i] < 255) mdc[i]++;
          end
        end
        if (ms[i] > 0) mhead[i] = mq[i][mh[i]];
      end
    end
    k++;
  end

  always @(posedge clk) begin
    string nm;
    #2;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        nm = (i == 0) ? "d1" : "d4";
        chk({nm, "_level"}, int'(lv[i]), ms[i]);
        chk({nm, "_valid"}, int'(mv[i]), int'(ms[i] > 0));
        chk({nm, "_overflow"}, int'(ov[i]), int'(mov[i]));
        chk({nm, "_drop_cnt"}, int'(dc[i]), mdc[i]);
        if (ms[i] > 0) chk({nm, "_data"}, int'(md[i]), int'(mhead[i]));
      end
    end
  end

  int  cyc = 0;
  bit  ramp = 1'b0;
  int  s;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ramp) filter_data = 16'(cyc);
  endtask

  initial begin
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", int'(mv[i]), 0);
      chk("rst_level", int'(lv[i]), 0);
      chk("rst_overflow", int'(ov[i]), 0);
      chk("rst_drop_cnt", int'(dc[i]), 0);
      chk("rst_data", int'(md[i]), 0);
    end
    rst_n = 1'b1;
    tick();

`ifndef FILTER_CAPTURE_WARMUP_SKIP_EN
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (4) tick();
    chk("pulse_pre_valid", int'(mv[0]), 0);
    filter_data = 16'h1234;
    tick();
    filter_data = '0;
    chk("pulse_data", int'(md[0]), 'h1234);
    chk("pulse_valid", int'(mv[0]), 1);
    chk("pulse_level", int'(lv[0]), 1);
    chk("pulse_d4_data", int'(md[1]), 'h1234);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("pulse_pop_valid", int'(mv[0]), 0);
    chk("pulse_pop_level", int'(lv[0]), 0);
`endif

    ramp = 1'b1;
    s = cyc;
    enable = 1'b1;
    repeat (40) tick();
    enable = 1'b0;
    repeat (LAT + 2) tick();
    ramp = 1'b0;
`ifdef FILTER_CAPTURE_WARMUP_SKIP_EN
    chk("warm_level", int'(lv[0]), 8);
    chk("warm_head", int'(md[0]), (s + 37) & 16'hFFFF);
    chk("warm_overflow", int'(ov[0]), 0);
    chk("warm_d4_level", int'(lv[1]), 2);
    chk("warm_d4_head", int'(md[1]), (s + 37) & 16'hFFFF);
`else
    chk("burst_level", int'(lv[0]), 16);
    chk("burst_overflow", int'(ov[0]), 1);
    chk("burst_drop_cnt", int'(dc[0]), 24);
    chk("burst_head", int'(md[0]), (s + 5) & 16'hFFFF);
    chk("burst_d4_level", int'(lv[1]), 10);
    chk("burst_d4_head", int'(md[1]), (s + 8) & 16'hFFFF);
    chk("burst_d4_drop", int'(dc[1]), 0);

    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (4) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("fullpp_level", int'(lv[0]), 16);
    chk("fullpp_drop_cnt", int'(dc[0]), 24);
    chk("fullpp_d4_level", int'(lv[1]), 9);
`endif

    m_ready = 1'b1;
    repeat (20) tick();
    m_ready = 1'b0;
    chk("drain_level", int'(lv[0]), 0);
    chk("drain_valid", int'(mv[0]), 0);

    enable = 1'b1;
    repeat (7) tick();
    enable = 1'b0;
    repeat (LAT) tick();
    chk("preclr_level", int'(lv[0]), 7);
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_level", int'(lv[0]), 0);
    chk("clr_valid", int'(mv[0]), 0);
    chk("clr_overflow", int'(ov[0]), 0);
    repeat (LAT + 1) begin
      tick();
      chk("clr_quiet_d1", int'(lv[0]), 0);
      chk("clr_quiet_d4", int'(lv[1]), 0);
    end

    for (int n = 0; n < 3000; n++) begin
      enable = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 3) < ((n < 1500) ? 1 : 3));
      clear = ($urandom_range(0, 149) == 0);
      filter_data = 16'($urandom);
      if (n == 2000) rst_n = 1'b0;
      if (n == 2003) rst_n = 1'b1;
      tick();
    end
    clear = 1'b0;

    m_ready = 1'b0;
    enable = 1'b1;
    repeat (320) tick();
    enable = 1'b0;
    repeat (LAT + 1) tick();
    chk("sat_drop_cnt", int'(dc[0]), 255);
    chk("sat_overflow", int'(ov[0]), 1);
    chk("sat_level", int'(lv[0]), 16);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
